// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode classification for alu_seq.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_LUI  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ops that may need the multi-cycle shift-add datapath.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift/multiply engine: one shift bit or one multiplier bit per cycle.
// done is asserted in the cycle whose step is the last one; result/carry then
// present the value after that step so the caller can register it directly.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand;
    logic [3:0]           op_r;

    logic [2*WIDTH-1:0]   step_acc;
    logic                 step_bit;
    logic [WIDTH:0]       sum;

    // One iteration: shift data lives in acc's low half; MUL keeps the
    // partial product in the high half and the multiplier in the low half.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        step_acc = acc;
        step_bit = 1'b0;
        case (op_r)
            OP_SHL: begin
                step_acc = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
                step_bit = acc[WIDTH-1];
            end
            OP_SHR: begin
                step_acc = {acc[2*WIDTH-1:WIDTH], 1'b0, acc[WIDTH-1:1]};
                step_bit = acc[0];
            end
            OP_MUL: begin
                step_acc = {sum, acc[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    assign done   = (count == CW'(1));
    assign result = step_acc[WIDTH-1:0];
    assign carry  = (op_r == OP_MUL) ? (|step_acc[2*WIDTH-1:WIDTH]) : step_bit;

    // Load operands on start, then step and count down until empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            acc   <= '0;
            mcand <= '0;
            op_r  <= '0;
        end else if (start) begin
            op_r  <= op;
            mcand <= a;
            if (op == OP_MUL) begin
                count <= CW'(WIDTH);
                acc   <= {{WIDTH{1'b0}}, b};
            end else begin
                count <= CW'(b[SHW-1:0]);
                acc   <= {{WIDTH{1'b0}}, a};
            end
        end else if (count != '0) begin
            acc   <= step_acc;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake on both sides. Single-cycle ops
// complete on the accept edge; SHL/SHR/MUL run in alu_iter_unit.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    state_t           state, state_next;
    logic             start;
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_carry;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;
    logic             iter_carry;

    // Combinational result for everything that finishes in one cycle,
    // returned as {carry, result}. Zero-amount shifts pass A through.
    function automatic logic [WIDTH:0] single_op(input logic [3:0]       f_op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             cin);
        logic [WIDTH:0] r;
        r = '0;
        case (f_op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_ADDC: r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_LUI:  r = {1'b0, b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SHL,
            OP_SHR:  r = {1'b0, a};
            default: r = '0;
        endcase
        return r;
    endfunction

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (in_a),
        .b      (in_b),
        .done   (iter_done),
        .result (iter_result),
        .carry  (iter_carry)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Handshake FSM next state plus output-register load selection.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        load       = 1'b0;
        load_res   = '0;
        load_carry = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if ((op == OP_MUL) ||
                        (is_iterative(op) && (in_b[SHW-1:0] != '0))) begin
                        state_next = BUSY;
                        start      = 1'b1;
                    end else begin
                        state_next = DONE;
                        load       = 1'b1;
                        {load_carry, load_res} = single_op(op, in_a, in_b, carry_in);
                    end
                end
            end
            BUSY: begin
                if (iter_done) begin
                    state_next = DONE;
                    load       = 1'b1;
                    load_res   = iter_result;
                    load_carry = iter_carry;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and result/flag registers, updated only on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                result    <= load_res;
                carry_out <= load_carry;
                zero      <= (load_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with WIDTH=16.
module tb_alu_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_a      (in_a),
        .in_b      (in_b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge, then wait for out_valid.
    // lat counts the accept edge as 1, so a single-cycle op reports 1.
    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output int lat);
        int edges;
        op = o; in_a = a; in_b = b; carry_in = cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op = 4'hF; in_a = 16'h5A5A; in_b = 16'hA5A5; carry_in = 1'b0;
        edges = 0;
        while (!out_valid && edges < 100) begin
            tick();
            edges++;
        end
        lat = edges + 1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic [15:0] exp_res,
                          input logic exp_c, input logic exp_z, input int exp_lat);
        int lat;
        issue(o, a, b, cin, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_carry"}, carry_out, exp_c);
        check({tag, "_zero"}, zero, exp_z);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; in_a = '0; in_b = '0; carry_in = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_carry", carry_out, 1'b0);
        check("rst_zero", zero, 1'b0);
        reset = 1'b0;
        tick();

        run_op("add",    4'd0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
        run_op("addc",   4'd1,  16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1);
        run_op("sub",    4'd2,  16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1);
        run_op("lui",    4'd6,  16'h7777, 16'h12AB, 1'b0, 16'hAB00, 1'b0, 1'b0, 1);
        run_op("and",    4'd3,  16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1);
        run_op("or",     4'd4,  16'hF000, 16'h000F, 1'b0, 16'hF00F, 1'b0, 1'b0, 1);
        run_op("xor",    4'd5,  16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
        run_op("illegal",4'd12, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b1, 1);
        run_op("shl1",   4'd7,  16'h8001, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 2);
        run_op("shr4",   4'd8,  16'h00F0, 16'h0004, 1'b0, 16'h000F, 1'b0, 1'b0, 5);
        run_op("shr3",   4'd8,  16'h000C, 16'h0003, 1'b0, 16'h0001, 1'b1, 1'b0, 4);
        run_op("shl0",   4'd7,  16'h8001, 16'h0010, 1'b0, 16'h8001, 1'b0, 1'b0, 1);
        run_op("mul_ov", 4'd9,  16'h0100, 16'h0101, 1'b0, 16'h0100, 1'b1, 1'b0, 17);
        run_op("mul",    4'd9,  16'h00FF, 16'h0002, 1'b0, 16'h01FE, 1'b0, 1'b0, 17);
        run_op("mul_big",4'd9,  16'h1234, 16'h0010, 1'b0, 16'h2340, 1'b1, 1'b0, 17);

        // Backpressure: DONE held with outputs frozen; a new request is ignored.
        issue(4'd0, 16'h1234, 16'h0001, 1'b0, lat);
        check("bp_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            op = 4'd2; in_a = 16'h0000; in_b = 16'h0001; in_valid = 1'b1;
            tick();
            check("bp_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_result", result, 16'h1235);
            check("bp_carry", carry_out, 1'b0);
            check("bp_zero", zero, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_ready", in_ready, 1'b1);
        tick();
        check("bp_not_queued", out_valid, 1'b0);

        // Reset in the middle of a MUL abandons it.
        op = 4'd9; in_a = 16'h00FF; in_b = 16'h00FF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_mul_busy", in_ready, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mul_valid", out_valid, 1'b0);
        check("rst_mul_ready", in_ready, 1'b1);
        check("rst_mul_result", result, 16'h0000);
        for (int i = 0; i < 20; i++) tick();
        check("rst_mul_abandoned", out_valid, 1'b0);
        run_op("add_after_rst", 4'd0, 16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
